// File: rtl/servant_arbiter_rr.sv
// Wishbone N:1 arbiter: round-robin or fixed priority, one transfer per grant,
// a one-cycle HOLD after each transfer and an optional BUSY timeout with error pulse.
module servant_arbiter_rr #(
    parameter int NUM_MASTERS = 3,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter     MODE        = "RR",
    parameter int TIMEOUT     = 255
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_MASTERS*AW-1:0]     i_wb_m_adr,
    input  logic [NUM_MASTERS*DW-1:0]     i_wb_m_dat,
    input  logic [NUM_MASTERS*DW/8-1:0]   i_wb_m_sel,
    input  logic [NUM_MASTERS-1:0]        i_wb_m_we,
    input  logic [NUM_MASTERS-1:0]        i_wb_m_cyc,
    output logic [DW-1:0]                 o_wb_m_rdt,
    output logic [NUM_MASTERS-1:0]        o_wb_m_ack,
    output logic [NUM_MASTERS-1:0]        o_wb_m_err,
    output logic [AW-1:0]                 o_wb_s_adr,
    output logic [DW-1:0]                 o_wb_s_dat,
    output logic [DW/8-1:0]               o_wb_s_sel,
    output logic                          o_wb_s_we,
    output logic                          o_wb_s_cyc,
    input  logic [DW-1:0]                 i_wb_s_rdt,
    input  logic                          i_wb_s_ack,
    output logic [NUM_MASTERS-1:0]        o_grant,
    output logic                          o_busy
);

    localparam int SW  = DW / 8;
    localparam int IW  = $clog2(NUM_MASTERS);
    localparam int CW  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit FIXED_PRIO = (MODE == "FIXED");
    localparam logic [CW-1:0] TO_LAST  = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    state_t                  state_q, state_d;
    logic [NUM_MASTERS-1:0]  grant_q, grant_d;
    logic [IW-1:0]           gidx_q, gidx_d;
    logic [IW-1:0]           ptr_q, ptr_d;
    logic [CW-1:0]           cnt_q, cnt_d;

    logic [AW-1:0]           m_adr [NUM_MASTERS];
    logic [DW-1:0]           m_dat [NUM_MASTERS];
    logic [SW-1:0]           m_sel [NUM_MASTERS];

    logic                    win_found;
    logic [IW-1:0]           win_idx;
    logic                    g_cyc;
    logic                    tmo_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
            assign m_adr[gi] = i_wb_m_adr[gi*AW +: AW];
            assign m_dat[gi] = i_wb_m_dat[gi*DW +: DW];
            assign m_sel[gi] = i_wb_m_sel[gi*SW +: SW];
        end
    endgenerate

    assign g_cyc   = i_wb_m_cyc[gidx_q];
    assign tmo_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    // Search upward from ptr (or from 0 in fixed mode) for the first requester.
    always_comb begin
        int            cand;
        logic [IW-1:0] cand_idx;
        cand      = 0;
        cand_idx  = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            cand     = FIXED_PRIO ? k : (int'(ptr_q) + k) % NUM_MASTERS;
            cand_idx = IW'(cand);
            if (!win_found && i_wb_m_cyc[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    gidx_d           = win_idx;
                    cnt_d            = '0;
                    state_d          = BUSY;
                end
            end
            BUSY: begin
                // Ack, master abort and timeout all end the transfer the same way.
                if ((g_cyc && i_wb_s_ack) || !g_cyc || tmo_hit) begin
                    grant_d = '0;
                    ptr_d   = (gidx_q == LAST_IDX) ? '0 : gidx_q + IW'(1);
                    state_d = HOLD;
                end else if (cnt_q != {CW{1'b1}}) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_busy     = (state_q == BUSY);
        o_wb_s_cyc = 1'b0;
        o_wb_s_we  = 1'b0;
        o_wb_s_adr = m_adr[gidx_q];
        o_wb_s_dat = m_dat[gidx_q];
        o_wb_s_sel = m_sel[gidx_q];
        o_wb_m_ack = '0;
        o_wb_m_err = '0;
        if (state_q == BUSY) begin
            o_wb_s_cyc = g_cyc;
            o_wb_s_we  = i_wb_m_we[gidx_q];
            // Reset in flight abandons the transfer without any response.
            if (g_cyc && !i_rst) begin
                o_wb_m_ack[gidx_q] = i_wb_s_ack;
                o_wb_m_err[gidx_q] = tmo_hit && !i_wb_s_ack;
            end
        end
    end

    assign o_grant    = grant_q;
    assign o_wb_m_rdt = i_wb_s_rdt;

endmodule

// File: doc/servant_arbiter_rr.md
SERVANT_ARBITER_RR -- requirements
Module: servant_arbiter_rr

Interface
REQ-001 Parameter NUM_MASTERS, default 3: number of Wishbone masters; legal range 2..8.
REQ-002 Parameter AW, default 32: address width.
REQ-003 Parameter DW, default 32: data width; select width is DW/8.
REQ-004 Parameter MODE, default "RR": "RR" selects round-robin priority, "FIXED" gives lowest index the highest priority.
REQ-005 Parameter TIMEOUT, default 255: maximum cycles in BUSY before abort; 0 disables the timeout.
REQ-006 Port i_clk, in, 1: the single clock; all logic on its rising edge.
REQ-007 Port i_rst, in, 1: synchronous active-high reset.
REQ-008 Port i_wb_m_adr, in, NUM_MASTERS*AW: master addresses, flattened with master k at [k*AW +: AW].
REQ-009 Port i_wb_m_dat, in, NUM_MASTERS*DW: master write data, flattened.
REQ-010 Port i_wb_m_sel, in, NUM_MASTERS*DW/8: master byte selects, flattened.
REQ-011 Port i_wb_m_we, in, NUM_MASTERS: master write enables.
REQ-012 Port i_wb_m_cyc, in, NUM_MASTERS: master cycle requests.
REQ-013 Port o_wb_m_rdt, out, DW: read data broadcast to all masters.
REQ-014 Port o_wb_m_ack, out, NUM_MASTERS: per-master acknowledge.
REQ-015 Port o_wb_m_err, out, NUM_MASTERS: per-master timeout error pulse.
REQ-016 Port o_wb_s_adr/o_wb_s_dat/o_wb_s_sel/o_wb_s_we/o_wb_s_cyc, out, AW/DW/DW/8/1/1: slave-side request.
REQ-017 Port i_wb_s_rdt, in, DW: slave read data; i_wb_s_ack, in, 1: slave acknowledge.
REQ-018 Port o_grant, out, NUM_MASTERS: registered one-hot grant, all zero when no master is granted.
REQ-019 Port o_busy, out, 1: high while in BUSY.

Function
REQ-020 FSM states are IDLE, BUSY and HOLD.
REQ-021 IDLE with any i_wb_m_cyc set: register the winner into o_grant, clear the timeout counter, go to BUSY next cycle; the latency from master cyc to slave cyc is 1 cycle.
REQ-022 RR winner: first requesting index at or after ptr, searching upward modulo NUM_MASTERS; FIXED winner: lowest requesting index, and ptr is ignored.
REQ-023 BUSY routing: o_wb_s_cyc = i_wb_m_cyc[g]; adr/dat/sel/we are taken from master g.
REQ-024 BUSY ack: o_wb_m_ack[g] = i_wb_s_ack combinationally; all other ack bits are 0 at all times.
REQ-025 BUSY completes on any of three events: ack; i_wb_m_cyc[g] low (abort, no ack forwarded); timeout counter == TIMEOUT-1 with TIMEOUT != 0.
REQ-026 On completion: o_grant cleared, ptr <= (g+1) mod NUM_MASTERS, next state HOLD.
REQ-027 If ack and timeout occur in the same cycle, ack wins and no err is issued.
REQ-028 On timeout: o_wb_m_err[g] pulses high for exactly that cycle, and o_wb_s_cyc is forced low from the next cycle.
REQ-029 HOLD lasts exactly 1 cycle with no grant, o_wb_s_cyc=0, then IDLE; this lets the master drop cyc after ack without being re-granted.
REQ-030 Timeout counter: increments each BUSY cycle; wide enough for TIMEOUT; saturates, never wraps.
REQ-031 o_wb_m_rdt = i_wb_s_rdt at all times.
REQ-032 Outside BUSY: o_wb_s_cyc=0, o_wb_s_we=0, and o_wb_s_adr/dat/sel are don't-care but driven.
REQ-033 A requester whose cyc is withdrawn in IDLE before being granted is simply not granted; no state change.

Reset
REQ-034 i_rst high at a clock edge: state IDLE, o_grant=0, ptr=0, counter=0, o_busy=0, o_wb_s_cyc=0, all ack/err 0.
REQ-035 Reset mid-BUSY: transfer abandoned silently, no ack or err issued, slave cyc low from the following cycle.

Verification (NUM_MASTERS=3, TIMEOUT=16, MODE="RR" unless noted)
REQ-036 Single request: m1 cyc with adr 0x100, we=0; slave acks 2 cycles after s_cyc with rdt 0xDEADBEEF -> o_grant=3'b010 one cycle after request; ack seen only on m1 with rdt 0xDEADBEEF; HOLD one cycle; ptr=2.
REQ-037 Round-robin: m0, m1, m2 hold cyc continuously; slave acks every request -> grant order 0,1,2,0 with one HOLD cycle between grants.
REQ-038 FIXED mode, same stimulus -> m0 is granted every time; m1 and m2 are never granted while m0 requests.
REQ-039 Timeout: m2 granted, slave never acks -> o_wb_m_err[2] is high exactly in the 16th BUSY cycle, s_cyc low on the next cycle, ptr=0.
REQ-040 Ack on the timeout cycle: slave acks in BUSY cycle 16 -> ack forwarded, err stays 0.
REQ-041 Abort and reset: m0 drops cyc in BUSY cycle 3 -> HOLD, no ack; then i_rst pulsed mid-BUSY of m1 -> all outputs return to reset values next cycle.
